// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
// Optional parity bit at end of frame is enabled with macro PISO_PARITY_EN.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   // A 2-bit word still needs a 1-bit counter, where $clog2(2) alone would be fine
   // but $clog2(1) would not; keep the width at least one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
// master = word producer / link observer, slave = serializer.
interface piso_serializer_if #(
   parameter int N = 4
);
   import piso_pkg::*;

   logic         load_valid;
   logic [N-1:0] D;
   logic         load_ready;
   logic         SO;
   logic         so_valid;
   logic         done;

   modport master (
      output load_valid, D,
      input  load_ready, SO, so_valid, done
   );

   modport slave (
      input  load_valid, D,
      output load_ready, SO, so_valid, done
   );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-N bit position counter with synchronous clear, enable and
// terminal-count flag (count == N-1).
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int               CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB first, with back-to-back frame reload.
// Define PISO_PARITY_EN to append an even parity bit to every frame.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int N = 4
) (
   input logic              clk,
   input logic              rst_n,
   piso_serializer_if.slave bus
);

   state_e       state_q;
   state_e       state_d;
   logic [N-1:0] sreg_q;
   logic [N-1:0] sreg_d;
`ifdef PISO_PARITY_EN
   logic         parity_q;
   logic         parity_d;
`endif

   logic load;
   logic cnt_clr;
   logic cnt_en;
   logic cnt_tc;
   logic ready;
   logic so;
   logic so_valid;
   logic done;

   piso_bit_counter #(.N(N)) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      load     = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      ready    = 1'b0;
      so       = 1'b0;
      so_valid = 1'b0;
      done     = 1'b0;

      case (state_q)
         IDLE: begin
            ready   = 1'b1;
            cnt_clr = 1'b1;
            load    = bus.load_valid;
         end
         SHIFT: begin
            so_valid = 1'b1;
            so       = sreg_q[0];
            cnt_en   = 1'b1;
            sreg_d   = {1'b0, sreg_q[N-1:1]};
            if (cnt_tc) begin
               cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
               state_d = PARITY;
`else
               done    = 1'b1;
               ready   = 1'b1;
               load    = bus.load_valid;
               state_d = IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            so_valid = 1'b1;
            so       = parity_q;
            done     = 1'b1;
            ready    = 1'b1;
            cnt_clr  = 1'b1;
            load     = bus.load_valid;
            state_d  = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // A handshake overrides the end-of-frame return to IDLE.
      if (load) begin
         sreg_d  = bus.D;
         state_d = SHIFT;
         cnt_clr = 1'b1;
      end
   end

`ifdef PISO_PARITY_EN
   assign parity_d = load ? ^bus.D : parity_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.load_ready = ready;
   assign bus.SO         = so;
   assign bus.so_valid   = so_valid;
   assign bus.done       = done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and random stimulus for piso_serializer, checked against a
// frame-queue reference model (pending serial bits of the frame in flight).
module tb_piso_serializer;

   localparam int N = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Bits still to appear on SO for the frame in flight, front = current cycle.
   bit   m_q[$];

   piso_serializer_if #(.N(N)) bus ();

   piso_serializer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic m_valid();
      return m_q.size() > 0;
   endfunction

   function automatic logic m_so();
      return (m_q.size() > 0) ? m_q[0] : 1'b0;
   endfunction

   function automatic logic m_done();
      return m_q.size() == 1;
   endfunction

   function automatic logic m_ready();
      return m_q.size() <= 1;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".so_valid"}, bus.so_valid, m_valid());
      chk({tag, ".SO"}, bus.SO, m_so());
      chk({tag, ".done"}, bus.done, m_done());
      chk({tag, ".load_ready"}, bus.load_ready, m_ready());
   endtask

   // Called at a falling edge: check this cycle's outputs, drive inputs for the
   // next rising edge, then advance the model across that edge.
   task automatic cycle(input string tag, input logic lv, input logic [N-1:0] d);
      bit accept;
      check_outputs(tag);
      bus.load_valid = lv;
      bus.D          = d;
      accept         = lv && m_ready();
      @(posedge clk);
      if (accept) begin
         m_q.delete();
         for (int i = 0; i < N; i++) m_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
         m_q.push_back(^d);
`endif
      end else if (m_q.size() > 0) begin
         void'(m_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic frame(input string tag, input logic [N-1:0] d);
      cycle(tag, 1'b1, d);
      for (int i = 0; i < N + 1; i++) cycle(tag, 1'b0, $urandom_range(0, 15));
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.load_valid = 1'b1;
      bus.D          = 4'hF;

      // Reset held for 3 cycles with load_valid high: outputs stay quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset.SO", bus.SO, 1'b0);
         chk("reset.so_valid", bus.so_valid, 1'b0);
         chk("reset.done", bus.done, 1'b0);
      end
      bus.load_valid = 1'b0;
      rst_n          = 1'b1;
      cycle("post_reset", 1'b0, 4'h0);

      frame("single_1011", 4'b1011);

      for (int i = 0; i < 4; i++) cycle("b2b_A", 1'b1, 4'hA);
      for (int i = 0; i < 4; i++) cycle("b2b_5", 1'b1, 4'h5);
      for (int i = 0; i < 2; i++) cycle("b2b_tail", 1'b0, 4'h0);

      cycle("ignored_3", 1'b1, 4'h3);
      cycle("ignored_3", 1'b0, 4'h3);
      cycle("ignored_F", 1'b1, 4'hF);
      for (int i = 0; i < N; i++) cycle("ignored_tail", 1'b0, 4'hF);

      // Reset asserted between edges during the second bit of 4'hC.
      cycle("midrst_C", 1'b1, 4'hC);
      cycle("midrst_C", 1'b0, 4'h0);
      #2 rst_n = 1'b0;
      m_q.delete();
      #1;
      chk("midrst.SO", bus.SO, 1'b0);
      chk("midrst.so_valid", bus.so_valid, 1'b0);
      chk("midrst.done", bus.done, 1'b0);
      @(negedge clk);
      chk("midrst_hold.done", bus.done, 1'b0);
      rst_n = 1'b1;
      frame("after_rst_9", 4'h9);

`ifdef PISO_PARITY_EN
      frame("parity_0111", 4'b0111);
      frame("parity_0011", 4'b0011);
`endif

      // Random load_valid/D traffic, including reloads on the last bit.
      for (int i = 0; i < 200; i++) begin
         cycle("random", 1'($urandom_range(0, 3) != 0), 4'($urandom));
      end
      for (int i = 0; i < N + 2; i++) cycle("drain", 1'b0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
